// File: rtl/cic_comp_pkg.sv
// Shared constants, coefficients and state type for the CIC droop-compensation FIR.
package cic_comp_pkg;

  localparam int COEF_W = 12;
  localparam int ACC_W  = 28;
  localparam int FRAC   = 10;

  // Symmetric half of the 9-tap impulse response, scaled by 2^FRAC.
  localparam logic signed [COEF_W-1:0] H0 = COEF_W'(-12);
  localparam logic signed [COEF_W-1:0] H1 = COEF_W'(34);
  localparam logic signed [COEF_W-1:0] H2 = COEF_W'(-86);
  localparam logic signed [COEF_W-1:0] H3 = COEF_W'(204);
  localparam logic signed [COEF_W-1:0] H4 = COEF_W'(768);

  typedef enum logic {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_e;

  // Coefficient used at MAC step k; step 4 is the centre tap.
  function automatic logic signed [COEF_W-1:0] coef_at(input logic [2:0] k);
    case (k)
      3'd0:    coef_at = H0;
      3'd1:    coef_at = H1;
      3'd2:    coef_at = H2;
      3'd3:    coef_at = H3;
      default: coef_at = H4;
    endcase
  endfunction

endpackage

// File: rtl/cic_comp_fir_mac.sv
// Pre-add / multiply / accumulate unit with a rounding output stage.
// rnd_o is the rounded, shifted value of acc + (a + b) * coef, valid in the
// same cycle the final step is presented.
module cic_comp_fir_mac
  import cic_comp_pkg::*;
#(
  parameter int DIN_W  = 13,
  parameter int DOUT_W = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DIN_W-1:0]  a_i,
  input  logic signed [DIN_W-1:0]  b_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [DOUT_W-1:0] rnd_o
);

  localparam int PRE_W  = DIN_W + 1;
  localparam int PROD_W = PRE_W + COEF_W;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1 << (FRAC - 1));

  logic signed [PRE_W-1:0]  a_ext, b_ext, pre;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, sum, rnd_sum;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  // Datapath: symmetric pre-add, multiply, accumulate, round half up.
  always_comb begin
    a_ext    = {a_i[DIN_W-1], a_i};
    b_ext    = {b_i[DIN_W-1], b_i};
    pre      = a_ext + b_ext;
    prod     = pre * coef_i;
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    sum      = acc_q + prod_ext;
    rnd_sum  = sum + RND;
    rnd_o    = DOUT_W'(rnd_sum >>> FRAC);
    acc_d    = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum;
    end
  end

  // Accumulator register; clear wins over enable so a new sample restarts cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/cic_comp_fir.sv
// 9-tap symmetric FIR compensating the droop of a decimate-by-5 CIC.
// One input sample every 5 clocks; a single MAC walks taps k = 0..4.
// Handshake: din_vld_i is a one-clock pulse, accepted only in IDLE or on the
// final MAC step; any other pulse is dropped and raises sticky ovf_o.
// dout_vld_o is a one-clock pulse; dout_o holds between pulses.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int DIN_W  = 13,
  parameter int DOUT_W = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_vld_i,
  input  logic signed [DIN_W-1:0]  din_i,
  output logic                     dout_vld_o,
  output logic signed [DOUT_W-1:0] dout_o,
  output logic                     ovf_o,
  output state_e                   dbg_state_o
);

  state_e                    state_q, state_d;
  logic [2:0]                k_q, k_d;
  logic signed [DIN_W-1:0]   x_q [0:8];
  logic                      ovf_q, ovf_d;
  logic                      dout_vld_q, dout_vld_d;
  logic signed [DOUT_W-1:0]  dout_q, dout_d;
  logic                      last, accept, mac_en;
  logic signed [DIN_W-1:0]   op_a, op_b;
  logic signed [COEF_W-1:0]  coef;
  logic signed [DOUT_W-1:0]  rnd;

  // Next-state, acceptance, overrun and output-register logic.
  always_comb begin
    last       = (state_q == MAC) && (k_q == 3'd4);
    accept     = din_vld_i && ((state_q == IDLE) || last);
    mac_en     = (state_q == MAC) && !last;
    state_d    = state_q;
    k_d        = k_q;
    if (accept) begin
      state_d = MAC;
      k_d     = 3'd0;
    end else if (state_q == MAC) begin
      if (last) state_d = IDLE;
      else      k_d     = k_q + 3'd1;
    end
    ovf_d      = ovf_q | (din_vld_i && (state_q == MAC) && !last);
    dout_vld_d = last;
    dout_d     = last ? rnd : dout_q;
  end

  // Tap pair selection for the current step; the centre tap has no partner.
  always_comb begin
    op_a = x_q[4];
    op_b = '0;
    case (k_q)
      3'd0:    begin op_a = x_q[0]; op_b = x_q[8]; end
      3'd1:    begin op_a = x_q[1]; op_b = x_q[7]; end
      3'd2:    begin op_a = x_q[2]; op_b = x_q[6]; end
      3'd3:    begin op_a = x_q[3]; op_b = x_q[5]; end
      default: begin op_a = x_q[4]; op_b = '0;     end
    endcase
    coef = coef_at(k_q);
  end

  // FSM, step counter, sticky overrun and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= 3'd0;
      ovf_q      <= 1'b0;
      dout_vld_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      ovf_q      <= ovf_d;
      dout_vld_q <= dout_vld_d;
      dout_q     <= dout_d;
    end
  end

  // Delay line shifts only on an accepted sample; dropped samples leave it intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) x_q[i] <= '0;
    end else if (accept) begin
      x_q[0] <= din_i;
      for (int i = 1; i < 9; i++) x_q[i] <= x_q[i-1];
    end
  end

  cic_comp_fir_mac #(
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .en_i   (mac_en),
    .a_i    (op_a),
    .b_i    (op_b),
    .coef_i (coef),
    .rnd_o  (rnd)
  );

  assign dout_vld_o  = dout_vld_q;
  assign dout_o      = dout_q;
  assign ovf_o       = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir with a queue-based scoreboard.
module tb_cic_comp_fir;
  import cic_comp_pkg::*;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic               din_vld_i;
  logic signed [12:0] din_i;
  logic               dout_vld_o;
  logic signed [13:0] dout_o;
  logic               ovf_o;
  state_e             dbg_state_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cic_comp_fir dut (
    .clk         (clk),
    .rst         (rst),
    .din_vld_i   (din_vld_i),
    .din_i       (din_i),
    .dout_vld_o  (dout_vld_o),
    .dout_o      (dout_o),
    .ovf_o       (ovf_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q[$];
  int          cyc_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per dout_vld pulse, checks value and latency.
  always @(posedge clk) begin : mon
    logic [13:0] e;
    int          c;
    #1;
    if (dout_vld_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_dout_vld: dout=%0d with nothing expected (cycle %0d)",
                 $signed(dout_o), cyc);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("dout", int'($signed(dout_o)), int'($signed(e)));
        check("latency", cyc, c);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One-clock din_vld pulse; next pulse starts `gap` clocks later.
  task automatic send(input int v, input int gap, input bit keep, input int e);
    @(negedge clk);
    din_vld_i = 1'b1;
    din_i     = 13'(v);
    if (keep) begin
      exp_q.push_back(14'(e));
      cyc_q.push_back(cyc + 6);
    end
    @(negedge clk);
    din_vld_i = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (8) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Hand-computed expected outputs.
  int imp_exp [10] = '{-12, 33, -84, 199, 750, 199, -84, 33, -12, 0};
  int dc_exp  [10] = '{-48, 88, -256, 560, 3631, 4447, 4103, 4239, 4191, 4191};
  int neg_exp [10] = '{4287, 4015, 4703, 3071, -3072, -4704, -4016, -4288, -4192, -4192};

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    din_vld_i = 1'b0;
    din_i     = '0;
    repeat (3) @(negedge clk);
    check("reset_dout", int'($signed(dout_o)), 0);
    check("reset_dout_vld", int'(dout_vld_o), 0);
    check("reset_ovf", int'(ovf_o), 0);
    check("reset_state", int'(dbg_state_o), int'(IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Impulse, spacing 5 (each new pulse coincides with k == 4).
    for (int i = 0; i < 10; i++) send((i == 0) ? 1000 : 0, 5, 1'b1, imp_exp[i]);
    drain();

    // DC positive full scale from an empty history.
    for (int i = 0; i < 10; i++) send(4095, 5, 1'b1, dc_exp[i]);
    drain();

    // Step from +4095 to negative full scale.
    for (int i = 0; i < 10; i++) send(-4096, 5, 1'b1, neg_exp[i]);
    drain();
    check("ovf_after_full_scale", int'(ovf_o), 0);

    // Overrun: pulses 3 apart; dropped samples leave the delay line intact.
    pulse_reset();
    check("ovf_before_overrun", int'(ovf_o), 0);
    send(1000, 3, 1'b1, -12);
    send(500,  3, 1'b0, 0);
    send(0,    3, 1'b1, 33);
    send(0,    2, 1'b0, 0);
    send(0,    5, 1'b1, -84);
    drain();
    check("ovf_sticky", int'(ovf_o), 1);

    // Reset during MAC step 2 aborts the computation.
    pulse_reset();
    @(negedge clk);
    din_vld_i = 1'b1;
    din_i     = 13'(1000);
    @(negedge clk);
    din_vld_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("state_mid_mac", int'(dbg_state_o), int'(MAC));
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_dout", int'($signed(dout_o)), 0);
    check("abort_ovf", int'(ovf_o), 0);
    check("abort_state", int'(dbg_state_o), int'(IDLE));
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 10; i++) send((i == 0) ? 1000 : 0, 5, 1'b1, imp_exp[i]);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cic_comp_fir.md
Name: cic_comp_fir

Overview:
- 9-tap symmetric FIR that compensates the passband droop of the single-stage decimate-by-5 CIC.
- Sits directly downstream of the CIC and consumes its output:
  - 13-bit samples at 40 kHz;
  - qualified by a one-clock valid pulse;
  - clk runs at 200 kHz, giving 5 clocks per input sample.
- Uses one time-multiplexed pre-add/multiply/accumulate unit, processing one symmetric coefficient per clock.

Parameters:
DIN_W, 13, input sample width (signed)
DOUT_W, 14, output sample width (signed)
COEF_W, 12, coefficient width (signed)
ACC_W, 28, accumulator width (signed)
FRAC, 10, right shift applied to the accumulator on output (coefficient scale 2^10)

Ports:
clk  in  1  system clock, 200 kHz
rst  in  1  asynchronous reset, active-high
din_vld  in  1  one-clock pulse marking a valid din (driven by the CIC rdy)
din  in  DIN_W  signed decimated CIC sample
dout_vld  out  1  one-clock pulse marking a valid dout
dout  out  DOUT_W  signed compensated sample, held between pulses
ovf  out  1  sticky overrun flag: a din_vld arrived while the MAC was busy

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset:
  - delay line x[0..8] = 0, acc = 0, k = 0, state = IDLE;
  - dout = 0, dout_vld = 0, ovf = 0.
- Coefficients h0..h4 = -12, 34, -86, 204, 768. Impulse response is h0 h1 h2 h3 h4 h3 h2 h1 h0, sum 1048 (DC gain 1048/1024).
- States:
  - IDLE: waiting for a sample.
  - MAC: step counter k = 0..4.
- Acceptance: din_vld sampled high in IDLE, or in MAC with k == 4. On that edge:
  - x[0] <= din; x[i] <= x[i-1] for i = 1..8;
  - acc <= 0, k <= 0, state <= MAC.
- MAC step k = 0..3, one per clock:
  - acc <= acc + (x[k] + x[8-k]) * h[k];
  - the pre-add is DIN_W+1 bits, the product is sign-extended to ACC_W;
  - k <= k+1.
- MAC step k = 4:
  - final = acc + x[4] * h4;
  - dout <= (final + 2^(FRAC-1)) >>> FRAC (round half up, arithmetic shift), truncated to DOUT_W;
  - dout_vld <= 1 for exactly this one clock;
  - state <= IDLE, unless a new acceptance occurs on the same edge, in which case acceptance has priority for state, k and acc.
- Latency: dout_vld rises 5 clocks after the edge at which din_vld was sampled. Sustained throughput is one sample per 5 clocks, matching the CIC exactly.
- Overrun: din_vld high in MAC with k < 4:
  - the sample is dropped and the delay line is untouched;
  - the current computation continues;
  - ovf <= 1, held until rst.
- Width: max |dout| = 4096 * 1440 / 1024 = 5760 < 2^13, so no saturation logic is required and 14 bits never overflow.
- dout holds its value between dout_vld pulses.
- Reset mid-MAC aborts the computation: no dout_vld is issued and the history is cleared.

Decomposition:
- Package cic_comp_pkg holds:
  - the h0..h4 coefficient constants;
  - COEF_W, ACC_W and FRAC;
  - the state enum {IDLE, MAC}.
- One natural sub-module: cic_comp_mac, containing the pre-adder, multiplier and accumulator, with clear/enable inputs and the rounding output stage.
- The top level contains the delay line, step counter/FSM, overrun flag and output registers.

Test Plan:
- Impulse: din = 1000 on one pulse, then 0 on pulses every 5 clocks.
  - dout sequence: -12, 33, -84, 199, 750, 199, -84, 33, -12, then 0.
  - Each dout_vld occurs 5 clocks after its din_vld.
- DC: din = 4095 on every pulse (spacing 5).
  - After 9 samples dout settles at 4191.
  - Before that, partial sums: first output -48, second 88.
- Negative full scale: din = -4096 constant.
  - dout settles at -4192.
  - No wrap; ovf stays 0.
- Overrun: din_vld pulses spaced 3 clocks.
  - The second sample is dropped and ovf = 1, sticky.
  - Exactly one dout_vld per accepted sample.
  - Spacing 5 with a pulse coincident with k == 4 gives no ovf and back-to-back outputs.
- Reset: assert rst during MAC step 2 of an impulse run.
  - No dout_vld is issued and dout = 0.
  - After release, an impulse of 1000 reproduces the exact sequence from the first test.
- Integration: drive the CIC with 200 kHz ramp data and connect rdy → din_vld, dout → din.
  - Output equals the reference model convolution of the CIC outputs, bit-exact.
